// File: rtl/ace_grant_controller_rr_pkg.sv
// Shared encodings and helpers for the descriptor grant controllers.
// The event-type and arbitration-mode encodings live here so that every grant controller uses the same values.
package ace_grant_controller_rr_pkg;

  typedef enum logic [1:0] {
    EV_FALL  = 2'd0,
    EV_RISE  = 2'd1,
    EV_LEVEL = 2'd2
  } ev_typ_e;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_DESC_MIN = 2;
  localparam int MAX_DESC_MAX = 64;

  // Next index after idx in a ring of n entries; n need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ace_grant_controller_rr_if.sv
// Request/grant bundle between the status inputs, the grant controller and the descriptor FSM.
interface ace_grant_controller_rr_if #(
  parameter int MAX_DESC = 16
);
  localparam int IDX_W = $clog2(MAX_DESC);
  localparam int CNT_W = $clog2(MAX_DESC + 1);

  logic [MAX_DESC-1:0] din;
  logic                gnt_rdy;
  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;
  logic [MAX_DESC-1:0] gnt_onehot;
  logic [MAX_DESC-1:0] pend_out;
  logic [CNT_W-1:0]    pend_cnt;

  modport slave (
    input  din, gnt_rdy,
    output gnt_vld, gnt_idx, gnt_onehot, pend_out, pend_cnt
  );

  modport master (
    output din, gnt_rdy,
    input  gnt_vld, gnt_idx, gnt_onehot, pend_out, pend_cnt
  );

endinterface

// File: rtl/ace_rr_picker.sv
// Combinational pick of the first set candidate at or above ptr, wrapping (mode=1),
// or the lowest set candidate (mode=0), via a double-width masked priority search.
module ace_rr_picker #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]   lo_mask;
  logic [2*N-1:0] dbl;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_mask
    assign lo_mask[gi] = !mode || (gi >= int'(ptr));
  end

  // Lower copy holds only entries at/above ptr; the upper copy supplies the wrapped tail.
  assign dbl = {cand, cand & lo_mask};

  always_comb begin
    int k;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    k      = 0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl[j]) begin
        found     = 1'b1;
        k         = (j < N) ? j : j - N;
        idx       = IDX_W'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ace_grant_controller_rr.sv
// Latches per-descriptor status events as sticky requests and hands them out one at a time
// through a registered valid/ready grant, fixed-priority or round-robin.
module ace_grant_controller_rr
  import ace_grant_controller_rr_pkg::*;
#(
  parameter int MAX_DESC = 16,
  parameter int EDGE_TYP = 1,
  parameter int ARB_MODE = 0
) (
  input logic clk,
  input logic rst_n,
  ace_grant_controller_rr_if.slave bus
);

  localparam int        IDX_W  = $clog2(MAX_DESC);
  localparam int        CNT_W  = $clog2(MAX_DESC + 1);
  localparam ev_typ_e   EV_TYP = ev_typ_e'(EDGE_TYP[1:0]);
  localparam arb_mode_e ARB    = arb_mode_e'(ARB_MODE[0]);

  logic [MAX_DESC-1:0] din_ff_reg;
  logic [MAX_DESC-1:0] pend_reg;
  logic [MAX_DESC-1:0] lvl_mask_reg;
  logic [MAX_DESC-1:0] gnt_onehot_reg;
  logic [IDX_W-1:0]    gnt_idx_reg;
  logic [IDX_W-1:0]    ptr_reg;
  logic                gnt_vld_reg;
  logic [CNT_W-1:0]    pend_cnt_reg;

  logic [MAX_DESC-1:0] ev;
  logic [MAX_DESC-1:0] acc_bit;
  logic [MAX_DESC-1:0] cand;
  logic [MAX_DESC-1:0] pend_next;
  logic [MAX_DESC-1:0] lvl_mask_next;
  logic [CNT_W-1:0]    pend_cnt_next;
  logic                accept;

  logic [MAX_DESC-1:0] pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;

  always_comb begin
    accept  = gnt_vld_reg & bus.gnt_rdy;
    acc_bit = accept ? gnt_onehot_reg : '0;

    // In level mode the accept in flight already counts as masked, so a held-high
    // line cannot re-arm itself in the same cycle its grant is taken.
    case (EV_TYP)
      EV_FALL: ev = ~bus.din & din_ff_reg;
      EV_RISE: ev = bus.din & ~din_ff_reg;
      default: ev = bus.din & ~(lvl_mask_reg | acc_bit);
    endcase

    pend_next     = ev | (pend_reg & ~acc_bit);
    lvl_mask_next = (EV_TYP == EV_LEVEL) ? ((lvl_mask_reg | acc_bit) & bus.din) : '0;
    cand          = pend_reg & ~acc_bit;

    pend_cnt_next = '0;
    for (int i = 0; i < MAX_DESC; i++) begin
      pend_cnt_next = pend_cnt_next + CNT_W'(pend_reg[i]);
    end
  end

  ace_rr_picker #(
    .N     (MAX_DESC),
    .IDX_W (IDX_W)
  ) u_picker (
    .cand   (cand),
    .ptr    (ptr_reg),
    .mode   (ARB == ARB_RR),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_ff_reg     <= '0;
      pend_reg       <= '0;
      lvl_mask_reg   <= '0;
      gnt_vld_reg    <= 1'b0;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
      pend_cnt_reg   <= '0;
      ptr_reg        <= '0;
    end else begin
      din_ff_reg   <= bus.din;
      pend_reg     <= pend_next;
      lvl_mask_reg <= lvl_mask_next;
      pend_cnt_reg <= pend_cnt_next;

      // The grant register only reloads when empty or being taken, so a stalled grant holds.
      if (!gnt_vld_reg || accept) begin
        gnt_vld_reg    <= pick_found;
        gnt_idx_reg    <= pick_found ? pick_idx : '0;
        gnt_onehot_reg <= pick_found ? pick_onehot : '0;
      end

      if (accept) begin
        ptr_reg <= IDX_W'(wrap_inc(int'(gnt_idx_reg), MAX_DESC));
      end
    end
  end

  assign bus.gnt_vld    = gnt_vld_reg;
  assign bus.gnt_idx    = gnt_idx_reg;
  assign bus.gnt_onehot = gnt_onehot_reg;
  assign bus.pend_out   = pend_reg;
  assign bus.pend_cnt   = pend_cnt_reg;

endmodule

// File: tb/tb_ace_grant_controller_rr.sv
// Bench for ace_grant_controller_rr: vector table, directed corner sequences and randomized
// traffic compared against a behavioural model, across four parameterisations.
module tb_ace_grant_controller_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_n_v;

  ace_grant_controller_rr_if #(.MAX_DESC(16)) bus_a ();
  ace_grant_controller_rr_if #(.MAX_DESC(5))  bus_b ();
  ace_grant_controller_rr_if #(.MAX_DESC(16)) bus_c ();
  ace_grant_controller_rr_if #(.MAX_DESC(64)) bus_d ();

  ace_grant_controller_rr #(.MAX_DESC(16), .EDGE_TYP(1), .ARB_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n_v[0]), .bus(bus_a.slave));
  ace_grant_controller_rr #(.MAX_DESC(5), .EDGE_TYP(1), .ARB_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n_v[1]), .bus(bus_b.slave));
  ace_grant_controller_rr #(.MAX_DESC(16), .EDGE_TYP(2), .ARB_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n_v[2]), .bus(bus_c.slave));
  ace_grant_controller_rr #(.MAX_DESC(64), .EDGE_TYP(0), .ARB_MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n_v[3]), .bus(bus_d.slave));

  int n_of   [4] = '{16, 5, 16, 64};
  int et_of  [4] = '{1, 1, 2, 0};
  int arb_of [4] = '{0, 1, 0, 0};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] prev;
    logic [63:0] pend;
    logic [63:0] lvl;
    bit          vld;
    int          idx;
    int          ptr;
    int          cnt;
  } mstate_t;

  typedef struct {
    logic        vld;
    logic [63:0] idx;
    logic [63:0] oh;
    logic [63:0] pend;
    logic [63:0] cnt;
  } obs_t;

  typedef struct {
    logic [15:0] din;
    bit          rdy;
    bit          vld;
    int          idx;
    logic [15:0] pend;
    int          cnt;
  } vec_t;

  mstate_t m [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int sel);
    return (n_of[sel] == 64) ? {64{1'b1}} : ((64'd1 << n_of[sel]) - 64'd1);
  endfunction

  function automatic logic [63:0] oh_of(input logic v, input int idx);
    return v ? (64'd1 << idx) : 64'd0;
  endfunction

  function automatic mstate_t mreset();
    mstate_t s;
    s.prev = '0; s.pend = '0; s.lvl = '0;
    s.vld = 1'b0; s.idx = 0; s.ptr = 0; s.cnt = 0;
    return s;
  endfunction

  // One clock of the controller, stated directly from its rules: events become pending,
  // an accepted grant clears its request unless a fresh event arrives, and the next grant is
  // the first waiting request scanning upward from the start point modulo the line count.
  function automatic mstate_t mstep(input mstate_t s, input logic [63:0] din, input bit rdy,
                                    input int sel);
    mstate_t nx;
    int n, et, start, k;
    bit acc, e, taken, found;
    n = n_of[sel];
    et = et_of[sel];
    nx = s;
    acc = s.vld && rdy;
    nx.cnt = 0;
    for (int i = 0; i < n; i++) if (s.pend[i]) nx.cnt++;
    for (int i = 0; i < n; i++) begin
      taken = acc && (s.idx == i);
      case (et)
        0:       e = !din[i] && s.prev[i];
        1:       e = din[i] && !s.prev[i];
        default: e = din[i] && !s.lvl[i] && !taken;
      endcase
      nx.pend[i] = e || (s.pend[i] && !taken);
      nx.lvl[i]  = (et == 2) && din[i] && (s.lvl[i] || taken);
      nx.prev[i] = din[i];
    end
    if (!s.vld || acc) begin
      found = 1'b0;
      nx.vld = 1'b0;
      nx.idx = 0;
      start = (arb_of[sel] == 1) ? s.ptr : 0;
      for (int o = 0; o < n; o++) begin
        k = (start + o) % n;
        if (!found && s.pend[k] && !(acc && s.idx == k)) begin
          found = 1'b1;
          nx.vld = 1'b1;
          nx.idx = k;
        end
      end
    end
    if (acc) nx.ptr = (s.idx + 1) % n;
    return nx;
  endfunction

  task automatic drive(input int sel, input logic [63:0] d, input bit r);
    case (sel)
      0:       begin bus_a.din = d[15:0]; bus_a.gnt_rdy = r; end
      1:       begin bus_b.din = d[4:0];  bus_b.gnt_rdy = r; end
      2:       begin bus_c.din = d[15:0]; bus_c.gnt_rdy = r; end
      default: begin bus_d.din = d;       bus_d.gnt_rdy = r; end
    endcase
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    case (sel)
      0: begin
        o.vld = bus_a.gnt_vld; o.idx = 64'(bus_a.gnt_idx); o.oh = 64'(bus_a.gnt_onehot);
        o.pend = 64'(bus_a.pend_out); o.cnt = 64'(bus_a.pend_cnt);
      end
      1: begin
        o.vld = bus_b.gnt_vld; o.idx = 64'(bus_b.gnt_idx); o.oh = 64'(bus_b.gnt_onehot);
        o.pend = 64'(bus_b.pend_out); o.cnt = 64'(bus_b.pend_cnt);
      end
      2: begin
        o.vld = bus_c.gnt_vld; o.idx = 64'(bus_c.gnt_idx); o.oh = 64'(bus_c.gnt_onehot);
        o.pend = 64'(bus_c.pend_out); o.cnt = 64'(bus_c.pend_cnt);
      end
      default: begin
        o.vld = bus_d.gnt_vld; o.idx = 64'(bus_d.gnt_idx); o.oh = bus_d.gnt_onehot;
        o.pend = bus_d.pend_out; o.cnt = 64'(bus_d.pend_cnt);
      end
    endcase
    return o;
  endfunction

  task automatic reset_inst(input int sel);
    drive(sel, 64'd0, 1'b0);
    rst_n_v[sel] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m[sel] = mreset();
    rst_n_v[sel] = 1'b1;
  endtask

  task automatic step_check(input int sel, input logic [63:0] d, input bit r);
    obs_t o;
    string t;
    drive(sel, d, r);
    @(posedge clk);
    m[sel] = mstep(m[sel], d, r, sel);
    #1;
    o = sample(sel);
    t = $sformatf("rand%0d", sel);
    chk({t, ".vld"},  64'(o.vld), 64'(m[sel].vld));
    chk({t, ".idx"},  o.idx, 64'(m[sel].idx));
    chk({t, ".oh"},   o.oh, oh_of(m[sel].vld, m[sel].idx));
    chk({t, ".pend"}, o.pend, m[sel].pend);
    chk({t, ".cnt"},  o.cnt, 64'(m[sel].cnt));
  endtask

  task automatic rand_phase(input int sel, input int cycles);
    logic [63:0] cur;
    int bad0;
    bad0 = bad;
    cur = '0;
    reset_inst(sel);
    for (int c = 0; c < cycles; c++) begin
      cur = cur ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & mask_of(sel));
      step_check(sel, cur, ($urandom_range(3) != 0));
    end
    $display("random inst=%0d cycles=%0d new_bad=%0d", sel, cycles, bad - bad0);
  endtask

  vec_t tbl [27];

  initial begin
    obs_t o;
    int q [$];
    int seen;

    tbl[0]  = '{16'h0208, 1'b1, 1'b0, 0,  16'h0208, 0};
    tbl[1]  = '{16'h0208, 1'b1, 1'b1, 3,  16'h0208, 2};
    tbl[2]  = '{16'h0208, 1'b1, 1'b1, 9,  16'h0200, 2};
    tbl[3]  = '{16'h0000, 1'b1, 1'b0, 0,  16'h0000, 1};
    tbl[4]  = '{16'h0000, 1'b1, 1'b0, 0,  16'h0000, 0};
    tbl[5]  = '{16'h0012, 1'b0, 1'b0, 0,  16'h0012, 0};
    tbl[6]  = '{16'h0012, 1'b0, 1'b1, 1,  16'h0012, 2};
    tbl[7]  = '{16'h0012, 1'b0, 1'b1, 1,  16'h0012, 2};
    tbl[8]  = '{16'h0012, 1'b0, 1'b1, 1,  16'h0012, 2};
    tbl[9]  = '{16'h0012, 1'b0, 1'b1, 1,  16'h0012, 2};
    tbl[10] = '{16'h0012, 1'b0, 1'b1, 1,  16'h0012, 2};
    tbl[11] = '{16'h0012, 1'b1, 1'b1, 4,  16'h0010, 2};
    tbl[12] = '{16'h0012, 1'b1, 1'b0, 0,  16'h0000, 1};
    tbl[13] = '{16'h0000, 1'b1, 1'b0, 0,  16'h0000, 0};
    tbl[14] = '{16'h0080, 1'b1, 1'b0, 0,  16'h0080, 0};
    tbl[15] = '{16'h0000, 1'b0, 1'b1, 7,  16'h0080, 1};
    tbl[16] = '{16'h0080, 1'b1, 1'b0, 0,  16'h0080, 1};
    tbl[17] = '{16'h0080, 1'b1, 1'b1, 7,  16'h0080, 1};
    tbl[18] = '{16'h0080, 1'b1, 1'b0, 0,  16'h0000, 1};
    tbl[19] = '{16'h0000, 1'b1, 1'b0, 0,  16'h0000, 0};
    tbl[20] = '{16'h0001, 1'b0, 1'b0, 0,  16'h0001, 0};
    tbl[21] = '{16'h0000, 1'b0, 1'b1, 0,  16'h0001, 1};
    tbl[22] = '{16'h0001, 1'b0, 1'b1, 0,  16'h0001, 1};
    tbl[23] = '{16'h0000, 1'b1, 1'b0, 0,  16'h0000, 1};
    tbl[24] = '{16'h8000, 1'b1, 1'b0, 0,  16'h8000, 0};
    tbl[25] = '{16'h8000, 1'b1, 1'b1, 15, 16'h8000, 1};
    tbl[26] = '{16'h8000, 1'b1, 1'b0, 0,  16'h0000, 1};

    rst_n_v = 4'b0000;
    for (int s = 0; s < 4; s++) drive(s, 64'd0, 1'b0);
    repeat (2) @(posedge clk);

    // Reset state and vector table on the fixed-priority rising-edge instance.
    reset_inst(0);
    o = sample(0);
    chk("reset.vld",  64'(o.vld), 64'd0);
    chk("reset.idx",  o.idx, 64'd0);
    chk("reset.oh",   o.oh, 64'd0);
    chk("reset.pend", o.pend, 64'd0);
    chk("reset.cnt",  o.cnt, 64'd0);

    for (int i = 0; i < 27; i++) begin
      drive(0, 64'(tbl[i].din), tbl[i].rdy);
      @(posedge clk);
      #1;
      o = sample(0);
      $display("vec %0d din=%h rdy=%0d -> vld=%0d idx=%0d pend=%h cnt=%0d",
               i, tbl[i].din, tbl[i].rdy, o.vld, o.idx, o.pend, o.cnt);
      chk($sformatf("vec%0d.vld", i),  64'(o.vld), 64'(tbl[i].vld));
      chk($sformatf("vec%0d.idx", i),  o.idx, 64'(tbl[i].idx));
      chk($sformatf("vec%0d.oh", i),   o.oh, oh_of(tbl[i].vld, tbl[i].idx));
      chk($sformatf("vec%0d.pend", i), o.pend, 64'(tbl[i].pend));
      chk($sformatf("vec%0d.cnt", i),  o.cnt, 64'(tbl[i].cnt));
    end
    rand_phase(0, 300);

    // Round-robin over five lines pulsed every six cycles: order wraps 4 -> 0.
    reset_inst(1);
    for (int c = 0; c < 13; c++) begin
      drive(1, (c % 6 == 0) ? 64'h1F : 64'h0, 1'b1);
      @(posedge clk);
      #1;
      o = sample(1);
      if (o.vld === 1'b1) q.push_back(int'(o.idx));
    end
    $display("rr order count=%0d", q.size());
    chk("rr.count", 64'(q.size()), 64'd10);
    for (int i = 0; i < q.size() && i < 10; i++) begin
      chk($sformatf("rr.order%0d", i), 64'(q[i]), 64'(i % 5));
    end
    rand_phase(1, 300);

    // Level mode: a held-high line is granted once per assertion.
    reset_inst(2);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      drive(2, 64'h4, 1'b1);
      @(posedge clk);
      #1;
      o = sample(2);
      if (o.vld === 1'b1 && o.idx == 64'd2) seen++;
    end
    $display("level held grants=%0d", seen);
    chk("lvl.held_grants", 64'(seen), 64'd1);
    chk("lvl.held_pend", o.pend, 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      drive(2, (c < 2) ? 64'h0 : 64'h4, 1'b1);
      @(posedge clk);
      #1;
      o = sample(2);
      if (o.vld === 1'b1 && o.idx == 64'd2) seen++;
    end
    $display("level reassert grants=%0d", seen);
    chk("lvl.reassert_grants", 64'(seen), 64'd1);
    rand_phase(2, 300);

    // Falling edge on the top line of a 64-wide instance, then reset while the grant is up.
    reset_inst(3);
    drive(3, 64'h8000_0000_0000_0000, 1'b0);
    @(posedge clk); #1;
    drive(3, 64'd0, 1'b0);
    @(posedge clk); #1;
    o = sample(3);
    chk("fall.pend", o.pend, 64'h8000_0000_0000_0000);
    @(posedge clk); #1;
    o = sample(3);
    chk("fall.vld", 64'(o.vld), 64'd1);
    chk("fall.idx", o.idx, 64'd63);
    chk("fall.oh",  o.oh, 64'h8000_0000_0000_0000);
    rst_n_v[3] = 1'b0;
    @(posedge clk); #1;
    o = sample(3);
    $display("mid-grant reset -> vld=%0d idx=%0d pend=%h", o.vld, o.idx, o.pend);
    chk("rst_mid.vld",  64'(o.vld), 64'd0);
    chk("rst_mid.idx",  o.idx, 64'd0);
    chk("rst_mid.oh",   o.oh, 64'd0);
    chk("rst_mid.pend", o.pend, 64'd0);
    chk("rst_mid.cnt",  o.cnt, 64'd0);
    rst_n_v[3] = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      drive(3, 64'd0, 1'b1);
      @(posedge clk); #1;
      o = sample(3);
      if (o.vld !== 1'b0) seen++;
    end
    chk("rst_mid.no_grant", 64'(seen), 64'd0);
    drive(3, 64'h8000_0000_0000_0000, 1'b1);
    @(posedge clk); #1;
    drive(3, 64'd0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    o = sample(3);
    chk("rst_after.vld", 64'(o.vld), 64'd1);
    chk("rst_after.idx", o.idx, 64'd63);
    rand_phase(3, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
